// File: rtl/intcode_bus_pkg.sv
// Shared constants for the intcode memory bus: master ids, RAM depth and the
// reserved I/O port addresses that are always out of range for the RAM arbiter.
package intcode_bus_pkg;
  localparam logic M_CPU    = 1'b0;
  localparam logic M_LOADER = 1'b1;

  localparam int RAM_SIZE_DEFAULT = 32768;

  localparam logic [31:0] IO_IN_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] IO_OUT_ADDR = 32'hFFFF_0001;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with an owner override for locked sequences and
// a cap on consecutive locked grants.
module rr_arbiter2
  import intcode_bus_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt,
  output logic       accept,
  output logic       winner
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          ptr_q, ptr_d;
  logic          own_vld_q, own_vld_d;
  logic          own_id_q, own_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          keep_lock;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (own_vld_q)          gnt[own_id_q] = req[own_id_q];
      else if (req == 2'b11)  gnt[ptr_q]    = 1'b1;
      else                    gnt           = req;
    end
  end

  assign accept    = |gnt;
  assign winner    = gnt[1];
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  // The accept that would bring the run to LOCK_MAX releases instead of locking.
  assign keep_lock = lock[winner] && (cnt_inc < (CW+1)'(LOCK_MAX));

  always_comb begin
    ptr_d     = ptr_q;
    own_vld_d = own_vld_q;
    own_id_d  = own_id_q;
    cnt_d     = cnt_q;
    if (accept) begin
      if (keep_lock) begin
        own_vld_d = 1'b1;
        own_id_d  = winner;
        cnt_d     = cnt_inc[CW-1:0];
        if (!own_vld_q) ptr_d = ~winner;
      end else begin
        own_vld_d = 1'b0;
        cnt_d     = '0;
        ptr_d     = ~winner;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= M_CPU;
      own_vld_q <= 1'b0;
      own_id_q  <= M_CPU;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      own_vld_q <= own_vld_d;
      own_id_q  <= own_id_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/intcode_mem_arbiter.sv
// Shares the single-port intcode RAM between the CPU (m0) and the loader (m1),
// filtering out-of-range addresses locally and routing responses by tag.
module intcode_mem_arbiter
  import intcode_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RAM_SIZE = RAM_SIZE_DEFAULT,
  parameter int LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(RAM_SIZE);

  logic [1:0]        gnt;
  logic              accept, winner;
  logic [ADDR_W-1:0] sel_addr_p0, addr_hold;
  logic [DATA_W-1:0] sel_wdata_p0, wdata_hold;
  logic              sel_we_p0, in_range_p0;
  logic              vld_p1, err_p1, tag_p1;

  rr_arbiter2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({m1_req, m0_req}),
    .lock   ({m1_lock, m0_lock}),
    .gnt    (gnt),
    .accept (accept),
    .winner (winner)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // p0: accept cycle, RAM driven straight from the winning master
  assign sel_addr_p0  = winner ? m1_addr  : m0_addr;
  assign sel_wdata_p0 = winner ? m1_wdata : m0_wdata;
  assign sel_we_p0    = winner ? m1_we    : m0_we;
  assign in_range_p0  = sel_addr_p0 < ADDR_LIMIT;

  assign ram_we    = accept && in_range_p0 && sel_we_p0;
  assign ram_re    = accept && in_range_p0 && !sel_we_p0;
  assign ram_addr  = accept ? sel_addr_p0  : addr_hold;
  assign ram_wdata = accept ? sel_wdata_p0 : wdata_hold;

  always_ff @(posedge clock) begin
    if (accept) begin
      addr_hold  <= sel_addr_p0;
      wdata_hold <= sel_wdata_p0;
    end
  end

  // p1: response cycle, tag routes it back to the issuing master
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      tag_p1 <= M_CPU;
    end else begin
      vld_p1 <= accept && (!sel_we_p0 || !in_range_p0);
      err_p1 <= accept && !in_range_p0;
      tag_p1 <= winner;
    end
  end

  assign m0_rvalid = vld_p1 && (tag_p1 == M_CPU);
  assign m1_rvalid = vld_p1 && (tag_p1 == M_LOADER);
  assign m0_err    = m0_rvalid && err_p1;
  assign m1_err    = m1_rvalid && err_p1;
  assign m0_rdata  = (m0_rvalid && !err_p1) ? ram_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !err_p1) ? ram_rdata : '0;

endmodule

// File: tb/tb_intcode_mem_arbiter.sv
// Directed and randomized bench for intcode_mem_arbiter against a transaction
// level model of arbitration, locking and response routing.
module tb_intcode_mem_arbiter;
  import intcode_bus_pkg::*;

  localparam int RS   = 32768;
  localparam int LMAX = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  int checks = 0;
  int errors = 0;

  intcode_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_SIZE(RS), .LOCK_MAX(LMAX)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Environment RAM: registered read, one cycle latency
  logic [31:0] ram     [RS];
  logic [31:0] ref_mem [RS];
  always @(posedge clock) begin
    if (ram_we) ram[ram_addr[14:0]] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr[14:0]];
  end

  // Reference model state
  int          ptr, owner, run;
  bit          ev, eerr;
  int          etag;
  logic [31:0] edata, last_addr, last_wdata;
  bit          have_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic r0, input logic r1);
    if (owner == 0) return r0 ? 0 : -1;
    if (owner == 1) return r1 ? 1 : -1;
    if (r0 && r1)   return ptr;
    if (r0)         return 0;
    if (r1)         return 1;
    return -1;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(output int w);
    logic [31:0] a, d;
    bit          we_b, lk, inr;
    #1;
    w    = pick(m0_req, m1_req);
    a    = (w == 1) ? m1_addr  : m0_addr;
    d    = (w == 1) ? m1_wdata : m0_wdata;
    we_b = (w == 1) ? m1_we    : m0_we;
    lk   = (w == 1) ? m1_lock  : m0_lock;
    inr  = (a < RS);
    chk("m0_gnt", m0_gnt, w == 0);
    chk("m1_gnt", m1_gnt, w == 1);
    chk("ram_we", ram_we, (w >= 0) && inr && we_b);
    chk("ram_re", ram_re, (w >= 0) && inr && !we_b);
    if (w >= 0) begin
      chk("ram_addr", ram_addr, a);
      chk("ram_wdata", ram_wdata, d);
    end else if (have_last) begin
      chk("ram_addr_hold", ram_addr, last_addr);
      chk("ram_wdata_hold", ram_wdata, last_wdata);
    end
    chk("m0_rvalid", m0_rvalid, ev && etag == 0);
    chk("m1_rvalid", m1_rvalid, ev && etag == 1);
    if (ev && etag == 0) begin
      chk("m0_err", m0_err, eerr);
      chk("m0_rdata", m0_rdata, edata);
    end
    if (ev && etag == 1) begin
      chk("m1_err", m1_err, eerr);
      chk("m1_rdata", m1_rdata, edata);
    end
    @(posedge clock);
    ev = 0;
    if (w >= 0) begin
      have_last  = 1;
      last_addr  = a;
      last_wdata = d;
      if (!we_b || !inr) begin
        ev    = 1;
        etag  = w;
        eerr  = !inr;
        edata = inr ? ref_mem[a[14:0]] : 32'h0;
      end
      if (we_b && inr) ref_mem[a[14:0]] = d;
      if (lk && run + 1 < LMAX) begin
        if (owner < 0) ptr = 1 - w;
        owner = w;
        run++;
      end else begin
        owner = -1;
        run   = 0;
        ptr   = 1 - w;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    #1;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst_m0_err", m0_err, 1'b0);
    chk("rst_m1_err", m1_err, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_re", ram_re, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    ptr = 0; owner = -1; run = 0; ev = 0;
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 9))
      0:       return 32'd40000;
      1:       return RS - 1;
      2:       return RS;
      3:       return IO_IN_ADDR;
      4:       return IO_OUT_ADDR;
      default: return $urandom_range(0, 63);
    endcase
  endfunction

  task automatic new_txn(input int m);
    logic        r, w_b, l;
    logic [31:0] a, d;
    r   = ($urandom_range(0, 2) != 0);
    w_b = $urandom_range(0, 1);
    l   = ($urandom_range(0, 3) == 0);
    a   = raddr();
    d   = $urandom;
    if (m == 0) begin
      m0_req = r; m0_we = w_b; m0_lock = l; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_we = w_b; m1_lock = l; m1_addr = a; m1_wdata = d;
    end
  endtask

  initial begin
    int w;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    have_last = 0;
    for (int i = 0; i < RS; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram[5]     = 32'h2A;
    ref_mem[5] = 32'h2A;
    @(negedge clock);
    do_reset();

    // m0 read of address 5
    m0_req = 1; m0_addr = 5;
    step(w);
    m0_req = 0;
    chk("rd5_rvalid", m0_rvalid, 1'b1);
    chk("rd5_rdata", m0_rdata, 32'h2A);
    step(w);

    // Both masters reading: grants alternate starting with m0
    do_reset();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    for (int i = 0; i < 4; i++) begin
      m0_addr = i; m1_addr = 16 + i;
      step(w);
      chk("alt_winner", w, i % 2);
    end
    m0_req = 0; m1_req = 0;
    step(w);

    // Out-of-range write from m1
    m1_req = 1; m1_we = 1; m1_addr = 40000; m1_wdata = 7;
    step(w);
    m1_req = 0; m1_we = 0;
    chk("oor_m1_err", m1_err, 1'b1);
    chk("oor_m1_rdata", m1_rdata, 32'h0);
    step(w);

    // Locked read then unlocking write by m0 while m1 waits
    m1_req = 1; m1_addr = 9;
    m0_req = 1; m0_lock = 1; m0_addr = 3; m0_we = 0;
    step(w);
    chk("lock_first", w, 0);
    m0_req = 0;
    step(w);
    chk("lock_idle0", w, -1);
    step(w);
    chk("lock_idle1", w, -1);
    m0_req = 1; m0_we = 1; m0_lock = 0; m0_wdata = 32'h55;
    step(w);
    chk("unlock_wr", w, 0);
    m0_req = 0; m0_we = 0;
    step(w);
    chk("after_unlock", w, 1);
    m1_req = 0;
    step(w);

    // Lock cap: m1 is granted after LOCK_MAX locked m0 grants
    m0_req = 1; m0_lock = 1; m1_req = 1;
    for (int i = 0; i < LMAX; i++) begin
      m0_addr = i;
      step(w);
      chk("cap_m0", w, 0);
    end
    step(w);
    chk("cap_m1", w, 1);
    m0_req = 0; m0_lock = 0; m1_req = 0;
    step(w);

    // Reset drops a read in flight
    m0_req = 1; m0_addr = 5;
    step(w);
    do_reset();
    m0_req = 1; m1_req = 1;
    step(w);
    chk("post_rst_first", w, 0);
    m0_req = 0; m1_req = 0;
    step(w);

    // Randomized traffic, requests held until accepted
    new_txn(0);
    new_txn(1);
    for (int i = 0; i < 400; i++) begin
      step(w);
      if (w == 0 || !m0_req) new_txn(0);
      if (w == 1 || !m1_req) new_txn(1);
    end
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    step(w);

    for (int i = 0; i < 64; i++) chk("mem", ram[i], ref_mem[i]);
    chk("mem_top", ram[RS-1], ref_mem[RS-1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intcode_mem_arbiter.md
Name: intcode_mem_arbiter

Overview:
- Shares the single-port intcode RAM between two bus masters: m0 is the intcode CPU and m1 is the program loader/debug port.
- Uses round-robin arbitration with an optional bus lock, so a master can keep the RAM for multi-cycle read-modify-write sequences.
- Rejects out-of-range addresses locally with an error response instead of forwarding them to the RAM.
- Sits between the masters and the RAM and replaces the shared tristate data bus with split read/write data paths.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- RAM_SIZE, 32768: number of RAM words; valid addresses are 0 .. RAM_SIZE-1.
- LOCK_MAX, 16: maximum consecutive locked grants before the lock is forcibly released.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- m0_req, m1_req  in  1  transaction request; held until accepted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_lock, m1_lock  in  1  request to keep ownership after this transaction.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_gnt, m1_gnt  out  1  combinational accept; the transaction is taken at the edge where req&&gnt.
- m0_rvalid, m1_rvalid  out  1  read response or error response valid.
- m0_rdata, m1_rdata  out  DATA_W  read data.
- m0_err, m1_err  out  1  address out of range; qualified by rvalid.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  DATA_W  registered RAM read data, valid one cycle after ram_re.

Behaviour:
- Reset (async, clears immediately):
  - All gnt, rvalid, err, ram_we, ram_re = 0; rdata = 0.
  - Priority pointer = m0; owner = none; lock counter = 0.
  - Any read in flight is dropped and its rvalid is never issued.
  - While reset is high, gnt outputs are forced to 0.
- Throughput: at most one transaction accepted per cycle; back-to-back accepts are allowed, including alternating masters.
- Grant selection (combinational, evaluated every cycle):
  - If owner = mX: only mX can be granted; the other master waits.
  - Else, one requester: grant it.
  - Else, both requesting: grant the master named by the pointer.
  - Exactly one gnt may be high in any cycle (one-hot or zero).
- Pointer update: on each accept with no owner set, the pointer moves to the non-winning master.
- RAM drive in the accept cycle (combinational from the winner):
  - ram_addr = winner addr; ram_wdata = winner wdata.
  - In range: ram_we = we; ram_re = !we.
  - Out of range (addr >= RAM_SIZE): ram_we = ram_re = 0.
  - No accept: ram_we = ram_re = 0; ram_addr and ram_wdata hold their last value.
- Read latency: mX_rvalid is high for exactly one cycle, at accept cycle + 1, with mX_rdata = ram_rdata.
- Writes complete at the accept edge and produce no rvalid.
- Out-of-range access (read or write): rvalid = 1 and err = 1 at accept + 1, rdata = 0; RAM is untouched.
- Response tagging: a one-bit tag registered at accept routes the response; a response always goes to the master that issued it, even if the other master is granted in the same cycle.
- Lock:
  - Accept with lock = 1 sets owner = that master and increments the lock counter.
  - Accept by the owner with lock = 0 clears owner and the counter; the pointer then moves to the other master.
  - When the counter reaches LOCK_MAX at an accept: owner is cleared, the pointer moves to the other master, and the lock bit of that accept is ignored.
  - The other master then gets the next grant if it is requesting.
- Owner idle: if the owner holds req = 0, the bus stays reserved (no timeout); only a transaction with lock = 0, the LOCK_MAX cap, or reset releases it.
- Simultaneous events: a new accept and the rvalid of the previous read may occur in the same cycle; both are handled independently.

Decomposition:
- Package intcode_bus_pkg:
  - master id constants M_CPU = 0, M_LOADER = 1;
  - RAM_SIZE default;
  - I/O port addresses 32'hFFFF0000 (input) and 32'hFFFF0001 (output), reserved for the later I/O decoder and always out of range for this block.
- Sub-module rr_arbiter2: the 2-way round-robin pick with owner override; holds the pointer, owner and lock counter registers and outputs a one-hot grant.

Test Plan:
- m0 read addr 5 with RAM[5] = 0x2A, m1 idle → m0_gnt in the same cycle; one cycle later m0_rvalid = 1, m0_rdata = 0x2A, m0_err = 0.
- m0 and m1 both request reads for 4 cycles, pointer = m0 after reset → grants alternate m0, m1, m0, m1; each rvalid goes to the correct master 1 cycle after its accept.
- m1 write addr 40000 data 7 → ram_we stays 0; m1_rvalid = m1_err = 1 one cycle later, m1_rdata = 0; RAM unchanged.
- m0 locked read addr 3, then m0 write addr 3 with lock = 0, while m1 requests continuously → m1 is not granted until the cycle after m0's unlock accept.
- m0 holds lock = 1 with continuous requests and m1 requests → after 16 m0 grants, m1 is granted next.
- Assert reset the cycle after an m0 read accept → no m0_rvalid appears; after release the pointer is m0 and both masters requesting grants m0 first.
